// File: rtl/adder_acc_pkg.sv
// rtl/adder_acc_pkg.sv - shared state encoding and sample width for the adder sum accumulator
package adder_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SAMPLE_W = 3;

endpackage

// File: rtl/sample_counter.sv
// rtl/sample_counter.sv - per-run sample counter with clear, enable and terminal-count flag
module sample_counter #(
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // High when the next accepted sample completes the run.
  assign last = (count == CNT_WIDTH'(NUM_SAMPLES - 1));

endmodule

// File: rtl/adder_sum_accumulator.sv
// rtl/adder_sum_accumulator.sv - sums NUM_SAMPLES adder results per run with sticky overflow and done/ack
module adder_sum_accumulator
  import adder_acc_pkg::*;
#(
  parameter int ACC_WIDTH   = 8,
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic                 In_valid,
  input  logic                 Carry_in,
  input  logic [1:0]           Sum_in,
  input  logic                 Ack,
  output logic [ACC_WIDTH-1:0] Acc,
  output logic [CNT_WIDTH-1:0] Count,
  output logic                 Overflow,
  output logic                 Busy,
  output logic                 Done
);

  state_t                state;
  state_t                next_state;
  logic                  run_clear;
  logic                  take;
  logic                  last;
  logic [SAMPLE_W-1:0]   sample;
  logic [ACC_WIDTH:0]    sum_ext;

  assign sample  = {Carry_in, Sum_in};
  // One extra bit on the left captures the carry out of the accumulator.
  assign sum_ext = {1'b0, Acc} + {{(ACC_WIDTH + 1 - SAMPLE_W){1'b0}}, sample};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    run_clear  = 1'b0;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          run_clear  = 1'b1;
          next_state = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (In_valid) begin
          take = 1'b1;
          if (last) begin
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (Ack) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  sample_counter #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_sample_counter (
    .clk   (Clk),
    .rst_n (Rst_n),
    .clr   (run_clear),
    .en    (take),
    .count (Count),
    .last  (last)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Acc      <= '0;
      Overflow <= 1'b0;
    end else if (run_clear) begin
      Acc      <= '0;
      Overflow <= 1'b0;
    end else if (take) begin
      Acc      <= sum_ext[ACC_WIDTH-1:0];
      Overflow <= Overflow | sum_ext[ACC_WIDTH];
    end
  end

  // Status flags are registered from the next state so they align with the state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Busy <= (next_state == ST_ACCUM);
      Done <= (next_state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb/tb_adder_sum_accumulator.sv - scoreboard bench for adder_sum_accumulator (two parameter sets)
module tb_adder_sum_accumulator;

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: ACC_WIDTH=8, NUM_SAMPLES=4
  logic       start_a = 0, valid_a = 0, carry_a = 0, ack_a = 0;
  logic [1:0] sum_a = 0;
  logic [7:0] acc_a;
  logic [2:0] cnt_a;
  logic       ovf_a, busy_a, done_a;

  // Instance B: ACC_WIDTH=6, NUM_SAMPLES=16
  logic       start_b = 0, valid_b = 0, carry_b = 0, ack_b = 0;
  logic [1:0] sum_b = 0;
  logic [5:0] acc_b;
  logic [4:0] cnt_b;
  logic       ovf_b, busy_b, done_b;

  adder_sum_accumulator #(.ACC_WIDTH(8), .NUM_SAMPLES(4)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .Start(start_a), .In_valid(valid_a),
    .Carry_in(carry_a), .Sum_in(sum_a), .Ack(ack_a),
    .Acc(acc_a), .Count(cnt_a), .Overflow(ovf_a), .Busy(busy_a), .Done(done_a)
  );

  adder_sum_accumulator #(.ACC_WIDTH(6), .NUM_SAMPLES(16)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Start(start_b), .In_valid(valid_b),
    .Carry_in(carry_b), .Sum_in(sum_b), .Ack(ack_b),
    .Acc(acc_b), .Count(cnt_b), .Overflow(ovf_b), .Busy(busy_b), .Done(done_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic done_a_q = 0;
  logic done_b_q = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus on instance A (sel_b=0) or B (sel_b=1), then return to idle inputs.
  task automatic cyc(input bit sel_b, input bit s, input bit v, input bit c,
                     input bit [1:0] su, input bit a);
    if (sel_b) begin
      start_b = s; valid_b = v; carry_b = c; sum_b = su; ack_b = a;
    end else begin
      start_a = s; valid_a = v; carry_a = c; sum_a = su; ack_a = a;
    end
    @(posedge clk);
    #1;
    start_a = 0; valid_a = 0; carry_a = 0; sum_a = 0; ack_a = 0;
    start_b = 0; valid_b = 0; carry_b = 0; sum_b = 0; ack_b = 0;
  endtask

  task automatic push_a(input int acc, input int cnt, input int ovf);
    exp_t e;
    e.acc = acc; e.cnt = cnt; e.ovf = ovf;
    q_a.push_back(e);
  endtask

  // Scoreboard monitor: compares the run result whenever Done rises.
  always @(negedge clk) begin
    exp_t e;
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) begin
        check("sb_a_unexpected_done", 1, 0);
      end else begin
        e = q_a.pop_front();
        check("sb_a_acc", int'(acc_a), e.acc);
        check("sb_a_count", int'(cnt_a), e.cnt);
        check("sb_a_overflow", int'(ovf_a), e.ovf);
      end
    end
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) begin
        check("sb_b_unexpected_done", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("sb_b_acc", int'(acc_b), e.acc);
        check("sb_b_count", int'(cnt_b), e.cnt);
        check("sb_b_overflow", int'(ovf_b), e.ovf);
      end
    end
    done_a_q = done_a;
    done_b_q = done_b;
  end

  initial begin
    exp_t eb;
    repeat (2) @(posedge clk);
    #1;
    check("reset_acc", int'(acc_a), 0);
    check("reset_count", int'(cnt_a), 0);
    check("reset_flags", int'({ovf_a, busy_a, done_a}), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic run: 4 x 3 = 12
    push_a(12, 4, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    check("basic_busy_after_start", int'(busy_a), 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("basic_not_done_early", int'(done_a), 0);
      cyc(0, 0, 1, 0, 2'd3, 0);
    end
    check("basic_done", int'(done_a), 1);
    check("basic_busy_low", int'(busy_a), 0);
    cyc(0, 0, 0, 0, 2'd0, 0);
    check("basic_done_holds", int'(done_a), 1);
    cyc(0, 0, 0, 0, 2'd0, 1);
    check("basic_done_after_ack", int'(done_a), 0);
    check("basic_acc_after_ack", int'(acc_a), 12);

    // Gapped valid: 1,2,3,6 with gaps 0,3,1
    push_a(12, 4, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    cyc(0, 0, 1, 0, 2'd1, 0);
    cyc(0, 0, 1, 0, 2'd2, 0);
    repeat (3) cyc(0, 0, 0, 0, 2'd0, 0);
    check("gap_acc_mid", int'(acc_a), 3);
    cyc(0, 0, 1, 0, 2'd3, 0);
    cyc(0, 0, 0, 0, 2'd0, 0);
    check("gap_count_3", int'(cnt_a), 3);
    check("gap_not_done", int'(done_a), 0);
    cyc(0, 0, 1, 1, 2'd2, 0);
    check("gap_done_after_4th", int'(done_a), 1);
    cyc(0, 0, 0, 0, 2'd0, 1);

    // Ignored controls: Start+valid in IDLE, Start mid-run, Start+Ack in DONE
    push_a(7, 4, 0);
    cyc(0, 1, 1, 1, 2'd1, 0);
    check("ign_start_valid_count", int'(cnt_a), 0);
    check("ign_start_valid_acc", int'(acc_a), 0);
    cyc(0, 0, 1, 0, 2'd1, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    check("ign_mid_start_acc", int'(acc_a), 1);
    check("ign_mid_start_count", int'(cnt_a), 1);
    cyc(0, 0, 1, 0, 2'd2, 0);
    cyc(0, 0, 1, 0, 2'd2, 0);
    cyc(0, 1, 1, 0, 2'd2, 0);
    check("ign_done", int'(done_a), 1);
    cyc(0, 1, 0, 0, 2'd0, 1);
    check("ign_start_ack_done", int'(done_a), 0);
    check("ign_start_ack_busy", int'(busy_a), 0);
    cyc(0, 0, 0, 0, 2'd0, 0);
    check("ign_idle_busy", int'(busy_a), 0);
    check("ign_idle_acc_kept", int'(acc_a), 7);

    // Reset mid-run, then 1,1,1,1
    cyc(0, 1, 0, 0, 2'd0, 0);
    cyc(0, 0, 1, 0, 2'd3, 0);
    cyc(0, 0, 1, 0, 2'd3, 0);
    check("rst_pre_acc", int'(acc_a), 6);
    rst_n = 0;
    #1;
    check("rst_async_acc", int'(acc_a), 0);
    check("rst_async_count", int'(cnt_a), 0);
    check("rst_async_busy", int'(busy_a), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    push_a(4, 4, 0);
    cyc(0, 1, 0, 0, 2'd0, 0);
    repeat (4) cyc(0, 0, 1, 0, 2'd1, 0);
    check("rst_rerun_done", int'(done_a), 1);
    cyc(0, 0, 0, 0, 2'd0, 1);

    // Overflow and wrap on B: 16 x 6 = 96 -> 32 mod 64
    eb.acc = 32; eb.cnt = 16; eb.ovf = 1;
    q_b.push_back(eb);
    cyc(1, 1, 0, 0, 2'd0, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 1, 1, 2'd2, 0);
      if (i == 10) check("ovf_b_not_yet", int'(ovf_b), 0);
      if (i == 11) begin
        check("ovf_b_wrap_acc", int'(acc_b), 2);
        check("ovf_b_set", int'(ovf_b), 1);
      end
    end
    check("ovf_b_done", int'(done_b), 1);
    repeat (2) cyc(1, 0, 0, 0, 2'd0, 0);
    check("ovf_b_sticky_done", int'(ovf_b), 1);
    check("ovf_b_acc_held", int'(acc_b), 32);
    cyc(1, 0, 0, 0, 2'd0, 1);
    check("ovf_b_after_ack", int'(ovf_b), 1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_a_drained", q_a.size(), 0);
    check("sb_b_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
